speaker_serializer: RTL
=======================

# speaker_serializer

Serial audio transmitter that consumes the parallel 16-bit left/right samples produced by the note generator and drives the Pmod I2S2 DAC pins (mclk, lrck, sck, sdin). It derives all DAC clocks from the 100 MHz system clock and captures one stereo sample pair per frame. It shifts each word out MSB-first and reports each capture with a one-cycle strobe. It sits between the audio source and the top-level speaker pins.

## Interface
- FRAME_BITS, 9: width of frame counter; frame = 2^FRAME_BITS clk (512).
- SAMPLE_W, 16: sample width; fixed at 16 for this DAC.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- audio_left  in  16  left sample, two's complement.
- audio_right  in  16  right sample, two's complement.
- audio_mclk  out  1  master clock, clk/4 (25 MHz).
- audio_lrck  out  1  word select, clk/512; 0 = left, 1 = right.
- audio_sck  out  1  bit clock, clk/16.
- audio_sdin  out  1  serial data, registered.
- sample_req  out  1  one-clk pulse: new pair captured; source may update.

## Operation
- Free-running counter cnt[8:0] increments every clk and wraps from 511 to 0.
- Clock outputs are taken directly from counter bits:
  - mclk = cnt[1]
  - sck = cnt[3]
  - lrck = cnt[8]
- Bit slot: s = cnt[8:4], range 0..31.
  - Slots 0–15 carry left bits 15..0.
  - Slots 16–31 carry right bits 15..0.
- Capture: on the clk edge where cnt==511, hold_l <= audio_left and hold_r <= audio_right.
  - Inputs are sampled only at that edge.
  - Changes to the inputs at any other time do not affect the frame in progress.
- sdin update:
  - sdin changes only on edges where cnt[3:0]==15, the same edge on which sck falls.
  - It takes the bit for slot (s+1) mod 32.
  - At cnt==511 the bit for slot 0 comes from audio_left[15] directly, coherent with the capture.
- sdin is therefore stable for 16 clk around each sck rising edge, with 8 clk setup and 8 clk hold.
- sample_req is registered and high exactly during the cycle in which cnt==0 after each capture. It pulses once every 512 clk.

## Timing
- Reset values: cnt=0, hold_l=hold_r=0, sdin=0, sample_req=0, so mclk=sck=lrck=0.
- After rst release:
  - The first capture occurs at cnt==511, i.e. 511 clk after release.
  - The first sample_req follows one clk later.
  - Frame 0 transmits all-zero words.
- Latency from the capture edge to the left MSB on sdin is 0 clk (left-justified). The right MSB appears 256 clk after the capture edge.
- Asserting rst mid-frame immediately forces all outputs low and discards the frame. The frame restarts from cnt=0 with no partial word.
- If audio_left changes in the same cycle that cnt==511, the value present at that edge is the one captured.

## Configuration
- SPK_I2S_DELAY_EN
  - Defined: standard I2S format. Each data bit lags by one slot, so sdin in slot s carries the bit of slot s−1.
    - Slot 0 carries the right LSB of the previous frame.
    - Slot 16 carries the left LSB of the current frame.
    - Implemented as a 1-bit delay register updated on the sck-falling edges.
    - The delay register resets to 0.
  - Undefined: left-justified format as described under Operation, so the MSB is coincident with the lrck edge.

## Structure
- Shared package spk_pkg holds:
  - SPK_FRAME_LEN = 512
  - SPK_SCK_DIV = 16
  - SPK_MCLK_DIV = 4
  - SPK_SLOTS = 32
  - typedef sample_t (16-bit signed)
- One sub-module, spk_clk_gen: contains the counter, produces mclk/sck/lrck, and emits the frame_end (cnt==511) and bit_edge (cnt[3:0]==15) strobes.
- The top level contains the hold registers, the bit select/shift logic, the sdin register and the sample_req register.

## Test plan
- Reset for 10 clk, then release:
  - All outputs are 0 during reset.
  - Periods after release: mclk 4 clk, sck 16 clk, lrck 512 clk.
  - sample_req first rises at clk 512 after release.
- audio_left=16'h8001, audio_right=16'h7FFE, macro undefined:
  - Sampling sdin at sck rising edges in frame 1 yields 1000_0000_0000_0001 followed by 0111_1111_1111_1110.
- Change audio_left to 16'hFFFF at cnt==100:
  - The current frame's left word is unchanged.
  - The next frame's left word is 16'hFFFF.
- Count sample_req over 10 frames:
  - Exactly 10 one-clk pulses, each spaced 512 clk apart.
- Assert rst at cnt==300 for 3 clk:
  - Outputs drop to 0 immediately.
  - After release, the counter restarts from 0, and the following frame carries the correct captured data.
- SPK_I2S_DELAY_EN defined with left=16'h8001, right=16'h0001:
  - Slot 0 = previous right LSB.
  - Slot 1 = 1 (left MSB).
  - Slot 16 = 1 (left LSB).
  - The next frame's slot 0 = 1 (right LSB).

Source files
------------

// File: rtl/spk_pkg.sv
// rtl/spk_pkg.sv - shared constants, sample type and slot-bit helper for speaker_serializer
//
// Purpose:
//   Frame/clock ratios of the Pmod I2S2 transmit path and a helper that
//   returns the serial bit carried by a given slot of a stereo frame.
// Contents:
//   SPK_FRAME_LEN  clk cycles per stereo frame (512)
//   SPK_SCK_DIV    clk cycles per bit clock (16)
//   SPK_MCLK_DIV   clk cycles per master clock (4)
//   SPK_SLOTS      bit slots per frame (32)
//   sample_t       16-bit signed audio sample
//   slot_bit()     bit for slot 0..31 (0..15 left MSB..LSB, 16..31 right MSB..LSB)
package spk_pkg;

  localparam int SPK_FRAME_LEN = 512;
  localparam int SPK_SCK_DIV   = 16;
  localparam int SPK_MCLK_DIV  = 4;
  localparam int SPK_SLOTS     = 32;

  typedef logic signed [15:0] sample_t;

  // Within a word, slot index k maps to bit 15-k, which for 4 bits is ~k.
  function automatic logic slot_bit(input logic [4:0] slot,
                                    input sample_t    left,
                                    input sample_t    right);
    return slot[4] ? right[~slot[3:0]] : left[~slot[3:0]];
  endfunction

endpackage

// File: rtl/spk_clk_gen.sv
// rtl/spk_clk_gen.sv - frame counter and DAC clock generation for speaker_serializer
//
// Purpose:
//   Free-running frame counter; every DAC clock is a counter bit so all
//   clocks stay phase-locked to the frame.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   o_mclk       out  master clock, clk/4
//   o_sck        out  bit clock, clk/16
//   o_lrck       out  word select, clk/512 (0 = left, 1 = right)
//   o_slot       out  current bit slot, 0..31
//   o_frame_end  out  high while the counter is at its last value (511)
//   o_bit_edge   out  high on the last clk of each bit slot (sck about to fall)
module spk_clk_gen
  import spk_pkg::*;
#(
  parameter int FRAME_BITS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_mclk,
  output logic                  o_sck,
  output logic                  o_lrck,
  output logic [FRAME_BITS-5:0] o_slot,
  output logic                  o_frame_end,
  output logic                  o_bit_edge
);

  logic [FRAME_BITS-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(FRAME_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign o_mclk      = r_cnt[1];
  assign o_sck       = r_cnt[3];
  assign o_lrck      = r_cnt[FRAME_BITS-1];
  assign o_slot      = r_cnt[FRAME_BITS-1:4];
  assign o_frame_end = &r_cnt;
  assign o_bit_edge  = &r_cnt[3:0];

endmodule

// File: rtl/speaker_serializer.sv
// rtl/speaker_serializer.sv - stereo 16-bit I2S/left-justified transmitter for the Pmod I2S2 DAC
//
// Purpose:
//   Captures one left/right sample pair per 512-clk frame and shifts both
//   words out MSB-first on audio_sdin, with DAC clocks derived from clk.
// Configuration:
//   SPK_I2S_DELAY_EN  defined   : standard I2S, data lags lrck by one slot
//                     undefined : left-justified, MSB coincident with lrck edge
// Ports:
//   clk          in   system clock, 100 MHz
//   rst          in   asynchronous active-high reset
//   audio_left   in   left sample, two's complement
//   audio_right  in   right sample, two's complement
//   audio_mclk   out  master clock, clk/4
//   audio_lrck   out  word select, clk/512
//   audio_sck    out  bit clock, clk/16
//   audio_sdin   out  registered serial data
//   sample_req   out  one-clk pulse after each capture
module speaker_serializer
  import spk_pkg::*;
#(
  parameter int FRAME_BITS = 9,
  parameter int SAMPLE_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin,
  output logic                sample_req
);

  logic [4:0] w_slot;
  logic [4:0] w_next_slot;
  logic       w_frame_end;
  logic       w_bit_edge;
  logic       w_next_bit;

  sample_t    r_hold_l;
  sample_t    r_hold_r;
  logic       r_sdin;
  logic       r_sample_req;
`ifdef SPK_I2S_DELAY_EN
  logic       r_dly;
`endif

  spk_clk_gen #(
    .FRAME_BITS (FRAME_BITS)
  ) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .o_mclk      (audio_mclk),
    .o_sck       (audio_sck),
    .o_lrck      (audio_lrck),
    .o_slot      (w_slot),
    .o_frame_end (w_frame_end),
    .o_bit_edge  (w_bit_edge)
  );

  assign w_next_slot = w_slot + 5'd1;

  // The next frame's slot 0 is loaded on the capture edge itself, so it must
  // come from the live input rather than the hold register being written.
  assign w_next_bit = w_frame_end ? audio_left[SAMPLE_W-1]
                                  : slot_bit(w_next_slot, r_hold_l, r_hold_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_sdin       <= 1'b0;
      r_sample_req <= 1'b0;
`ifdef SPK_I2S_DELAY_EN
      r_dly        <= 1'b0;
`endif
    end else begin
      r_sample_req <= w_frame_end;
      if (w_frame_end) begin
        r_hold_l <= audio_left;
        r_hold_r <= audio_right;
      end
      if (w_bit_edge) begin
`ifdef SPK_I2S_DELAY_EN
        // One-slot lag: slot 0 ends up carrying the previous right LSB.
        r_dly  <= w_next_bit;
        r_sdin <= r_dly;
`else
        r_sdin <= w_next_bit;
`endif
      end
    end
  end

  assign audio_sdin = r_sdin;
  assign sample_req = r_sample_req;

endmodule
